// File: rtl/booth_r4_multiplier_if.sv
// ----------------------------------------------------------------------------
// booth_r4_multiplier_if
// Handshake bundle for the iterative radix-4 Booth multiplier.
//
// Parameters:
//   WIDTH          operand width in bits (product is 2*WIDTH bits)
//
// Signals:
//   in_valid_in    producer -> multiplier : operand pair and mode are valid
//   in_ready_out   multiplier -> producer : an operand pair can be accepted
//   x_in           producer -> multiplier : multiplicand
//   y_in           producer -> multiplier : multiplier
//   signed_in      producer -> multiplier : 1 = two's complement, 0 = unsigned
//   result_out     multiplier -> consumer : registered product
//   out_valid_out  multiplier -> consumer : result_out holds a completed product
//   out_ready_in   consumer -> multiplier : consumer takes the product
//
// Modports:
//   master  the side that supplies operands and consumes products
//   slave   the multiplier itself
// ----------------------------------------------------------------------------
interface booth_r4_multiplier_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid_in;
    logic                   in_ready_out;
    logic [WIDTH-1:0]       x_in;
    logic [WIDTH-1:0]       y_in;
    logic                   signed_in;
    logic [2*WIDTH-1:0]     result_out;
    logic                   out_valid_out;
    logic                   out_ready_in;

    modport master (
        output in_valid_in,
        output x_in,
        output y_in,
        output signed_in,
        output out_ready_in,
        input  in_ready_out,
        input  result_out,
        input  out_valid_out
    );

    modport slave (
        input  in_valid_in,
        input  x_in,
        input  y_in,
        input  signed_in,
        input  out_ready_in,
        output in_ready_out,
        output result_out,
        output out_valid_out
    );
endinterface

// File: rtl/booth_r4_multiplier.sv
// ----------------------------------------------------------------------------
// booth_r4_multiplier
// Iterative radix-4 Booth multiplier. One operand pair is accepted in IDLE,
// WIDTH/2+1 Booth steps run in CALC (one per clock), and the product is held
// in DONE until the consumer takes it. Operations never overlap.
//
// Parameters:
//   WIDTH   operand width, must be even and >= 4; must match the WIDTH of
//           the connected interface instance
//
// Ports:
//   clk     clock, all state changes on the rising edge
//   rst_n   asynchronous active-low reset
//   bus     booth_r4_multiplier_if.slave (operand/product handshakes)
//
// Latency: with acceptance on edge A, out_valid_out rises after edge
// A+ITER. Minimum initiation interval is ITER+2 cycles.
// ----------------------------------------------------------------------------
module booth_r4_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    booth_r4_multiplier_if.slave    bus
);

    localparam int ITER  = WIDTH / 2 + 1;      // Booth steps per operation
    localparam int EXT_W = WIDTH + 2;          // operands after sign/zero extension
    localparam int ACC_W = 2 * WIDTH + 4;      // accumulator width
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    // mcand_reg holds the extended multiplicand already aligned to the
    // current step (shifted left by 2 each step), so the selected partial
    // product can be added without a variable shifter.
    logic [ACC_W-1:0]       mcand_reg;
    // mplr_reg shifts right by 2 each step so the current Booth triplet is
    // always {mplr_reg[1:0], prev_reg}; prev_reg carries y[2i-1].
    logic [EXT_W-1:0]       mplr_reg;
    logic                   prev_reg;
    logic [ACC_W-1:0]       acc_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [2*WIDTH-1:0]     result_reg;

    logic                   accept;
    logic                   last_step;
    logic [EXT_W-1:0]       x_ext;
    logic [EXT_W-1:0]       y_ext;
    logic [ACC_W-1:0]       pp;
    logic [ACC_W-1:0]       acc_sum;

    assign accept    = bus.in_valid_in && (state_reg == IDLE);
    assign last_step = (state_reg == CALC) && (cnt_reg == CNT_W'(1));

    // Two extra bits make an unsigned operand a non-negative two's-complement
    // value, so one signed Booth recoding serves both modes.
    assign x_ext = bus.signed_in ? {{2{bus.x_in[WIDTH-1]}}, bus.x_in} : {2'b00, bus.x_in};
    assign y_ext = bus.signed_in ? {{2{bus.y_in[WIDTH-1]}}, bus.y_in} : {2'b00, bus.y_in};

    // Booth digit selection: 0, +X, +2X, -X, -2X (modulo 2^ACC_W).
    always_comb begin
        pp = '0;
        case ({mplr_reg[1:0], prev_reg})
            3'b001, 3'b010: pp = mcand_reg;
            3'b011:         pp = mcand_reg << 1;
            3'b100:         pp = -(mcand_reg << 1);
            3'b101, 3'b110: pp = -mcand_reg;
            default:        pp = '0;
        endcase
    end

    assign acc_sum = acc_reg + pp;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)           state_next = CALC;
            CALC:    if (last_step)        state_next = DONE;
            DONE:    if (bus.out_ready_in) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready_out  = (state_reg == IDLE);
        bus.out_valid_out = (state_reg == DONE);
    end

    assign bus.result_out = result_reg;

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplr_reg   <= '0;
            prev_reg   <= 1'b0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        mcand_reg <= {{(ACC_W-EXT_W){x_ext[EXT_W-1]}}, x_ext};
                        mplr_reg  <= y_ext;
                        prev_reg  <= 1'b0;
                        acc_reg   <= '0;
                        cnt_reg   <= CNT_W'(ITER);
                    end
                end
                CALC: begin
                    acc_reg   <= acc_sum;
                    mcand_reg <= mcand_reg << 2;
                    mplr_reg  <= {2'b00, mplr_reg[EXT_W-1:2]};
                    prev_reg  <= mplr_reg[1];
                    cnt_reg   <= cnt_reg - 1'b1;
                    // The final step's sum goes straight to the output so
                    // out_valid_out and a valid result appear together.
                    if (last_step) begin
                        result_reg <= acc_sum[2*WIDTH-1:0];
                    end
                end
                default: begin
                    // DONE: hold everything; result_reg stays stable
                end
            endcase
        end
    end

endmodule
